// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU constants for the register file and its scoreboard.
//   DATA_W_DEF / ADDR_W_DEF : default register width and index width
//   ZERO_REG                : index of the hard-wired zero register
//   rd_src_e                : source selector for a read port
package cpu_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned ZERO_REG   = 0;

    typedef enum logic [1:0] {
        SRC_ZERO   = 2'd0,
        SRC_BYPASS = 2'd1,
        SRC_REG    = 2'd2
    } rd_src_e;

endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: one pending bit per register, tracking results not yet
// written back, and the decode stall derived from it.
//   clk, rst_n          : clock, synchronous active-low reset
//   set_en, set_idx     : issuing instruction's destination (taken only when not stalled)
//   clr_en, clr_idx     : write-back clearing its destination
//   rs_addr, rt_addr    : decode-stage source indices looked up
//   stall               : combinational; a source is still pending
// Optional macro REGISTER_FILE_BYPASS_EN: a source being written back this
// cycle is not counted as pending (the value is forwarded instead).
import cpu_pkg::*;

module reg_scoreboard #(
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_idx,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_idx,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic              stall
);

    localparam int unsigned NREG = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

    logic [NREG-1:0] pending;
    logic            rs_hit;
    logic            rt_hit;
    logic            set_ok;

    always_comb begin
        rs_hit = (rs_addr != ZERO_IDX) && pending[rs_addr];
        rt_hit = (rt_addr != ZERO_IDX) && pending[rt_addr];
`ifdef REGISTER_FILE_BYPASS_EN
        if (clr_en && (clr_idx == rs_addr)) rs_hit = 1'b0;
        if (clr_en && (clr_idx == rt_addr)) rt_hit = 1'b0;
`endif
        // Pending bits are undefined until the first reset edge; hold stall low meanwhile.
        stall  = rst_n && (rs_hit || rt_hit);
        set_ok = set_en && !stall && (set_idx != ZERO_IDX);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            // Set is applied after clear so a same-index issue wins.
            if (clr_en) pending[clr_idx] <= 1'b0;
            if (set_ok) pending[set_idx] <= 1'b1;
            pending[ZERO_REG] <= 1'b0;
        end
    end

endmodule

// File: rtl/register_file.sv
// register_file: 2^ADDR_W x DATA_W register file with registered dual read
// ports and a pending-write scoreboard that stalls decode on RAW hazards.
//   clk, rst_n           : clock, synchronous active-low reset
//   reg_write, wb_addr,
//   wb_data              : write-back port (register 0 ignores writes)
//   rs_addr, rt_addr     : source indices; rs_data/rt_data valid one cycle later
//   rs_data, rt_data     : registered operands, held while stall=1
//   issue_en, issue_dest : decode issuing an instruction that writes issue_dest
//   stall                : combinational hazard stall
// Optional macro REGISTER_FILE_BYPASS_EN: same-cycle write-back is forwarded
// to the read ports instead of stalling.
import cpu_pkg::*;

module register_file #(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_dest,
    output logic              stall
);

    localparam int unsigned NREG = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0] regs [NREG];
    rd_src_e           rs_src;
    rd_src_e           rt_src;
    logic [DATA_W-1:0] rs_next;
    logic [DATA_W-1:0] rt_next;

    reg_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk     (clk),
        .rst_n   (rst_n),
        .set_en  (issue_en),
        .set_idx (issue_dest),
        .clr_en  (reg_write),
        .clr_idx (wb_addr),
        .rs_addr (rs_addr),
        .rt_addr (rt_addr),
        .stall   (stall)
    );

    always_comb begin
        rs_src = SRC_REG;
        rt_src = SRC_REG;
        if (rs_addr == ZERO_IDX) rs_src = SRC_ZERO;
`ifdef REGISTER_FILE_BYPASS_EN
        else if (reg_write && (wb_addr == rs_addr)) rs_src = SRC_BYPASS;
`endif
        if (rt_addr == ZERO_IDX) rt_src = SRC_ZERO;
`ifdef REGISTER_FILE_BYPASS_EN
        else if (reg_write && (wb_addr == rt_addr)) rt_src = SRC_BYPASS;
`endif

        case (rs_src)
            SRC_ZERO:   rs_next = '0;
            SRC_BYPASS: rs_next = wb_data;
            default:    rs_next = regs[rs_addr];
        endcase
        case (rt_src)
            SRC_ZERO:   rt_next = '0;
            SRC_BYPASS: rt_next = wb_data;
            default:    rt_next = regs[rt_addr];
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (reg_write && (wb_addr != ZERO_IDX)) begin
            regs[wb_addr] <= wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rs_data <= '0;
            rt_data <= '0;
        end else if (!stall) begin
            rs_data <= rs_next;
            rt_data <= rt_next;
        end
    end

endmodule

// File: tb/tb_register_file.sv
module tb_register_file;

    logic        clk;
    logic        rst_n;
    logic        reg_write;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        issue_en;
    logic [4:0]  issue_dest;
    logic        stall;

    register_file #(
        .DATA_W (32),
        .ADDR_W (5)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .reg_write  (reg_write),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .rs_addr    (rs_addr),
        .rt_addr    (rt_addr),
        .rs_data    (rs_data),
        .rt_data    (rt_data),
        .issue_en   (issue_en),
        .issue_dest (issue_dest),
        .stall      (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic        ie;
        logic [4:0]  id;
        logic        st;   // expected stall during the cycle
        logic [31:0] er;   // expected rs_data after the edge
        logic [31:0] et;   // expected rt_data after the edge
    } vec_t;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q [$];

    function automatic vec_t mk(input logic r, input logic we, input logic [4:0] wa,
                                input logic [31:0] wd, input logic [4:0] ra,
                                input logic [4:0] rb, input logic ie, input logic [4:0] id,
                                input logic st, input logic [31:0] er, input logic [31:0] et);
        vec_t v;
        v.rst_n = r;  v.we = we; v.wa = wa; v.wd = wd; v.ra = ra; v.rb = rb;
        v.ie = ie;    v.id = id; v.st = st; v.er = er; v.et = et;
        return v;
    endfunction

    task automatic apply(input vec_t v, input string tag);
        logic [63:0] e;
        rst_n = v.rst_n; reg_write = v.we; wb_addr = v.wa; wb_data = v.wd;
        rs_addr = v.ra;  rt_addr = v.rb;   issue_en = v.ie; issue_dest = v.id;
        #1;
        checks++;
        if (stall !== v.st) begin
            errors++;
            $display("FAIL %s stall: got %b expected %b", tag, stall, v.st);
        end
        exp_q.push_back({v.er, v.et});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (rs_data !== e[63:32]) begin
            errors++;
            $display("FAIL %s rs_data: got %h expected %h", tag, rs_data, e[63:32]);
        end
        checks++;
        if (rt_data !== e[31:0]) begin
            errors++;
            $display("FAIL %s rt_data: got %h expected %h", tag, rt_data, e[31:0]);
        end
    endtask

    vec_t tbl [12];

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        //             rst we wa  wd            ra  rb  ie id  st  rs_data       rt_data
        tbl[0]  = mk(0, 1, 2,  32'h0000_00AA, 3,  4,  1, 9,  0, 32'h0,        32'h0);
        tbl[1]  = mk(1, 0, 0,  32'h0,         3,  4,  0, 0,  0, 32'h0,        32'h0);
        tbl[2]  = mk(1, 0, 0,  32'h0,         2,  9,  0, 0,  0, 32'h0,        32'h0);
        tbl[3]  = mk(1, 1, 5,  32'h0000_0009, 1,  1,  0, 0,  0, 32'h0,        32'h0);
        tbl[4]  = mk(1, 0, 0,  32'h0,         5,  5,  0, 0,  0, 32'h9,        32'h9);
        tbl[5]  = mk(1, 1, 0,  32'hFFFF_FFFF, 0,  5,  0, 0,  0, 32'h0,        32'h9);
        tbl[6]  = mk(1, 0, 0,  32'h0,         0,  0,  0, 0,  0, 32'h0,        32'h0);
        tbl[7]  = mk(1, 1, 6,  32'hDEAD_BEEF, 5,  5,  0, 0,  0, 32'h9,        32'h9);
        tbl[8]  = mk(1, 0, 0,  32'h0,         6,  5,  0, 0,  0, 32'hDEAD_BEEF, 32'h9);
        tbl[9]  = mk(1, 1, 5,  32'h0000_0012, 6,  6,  0, 0,  0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        tbl[10] = mk(1, 0, 0,  32'h0,         5,  0,  1, 0,  0, 32'h12,       32'h0);
        tbl[11] = mk(1, 0, 0,  32'h0,         0,  0,  0, 0,  0, 32'h0,        32'h0);

        foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

        // RAW hazard on r7; an issue attempted while stalled must be dropped.
        apply(mk(1, 0, 0, 32'h0,    6, 5, 1, 7,  0, 32'hDEAD_BEEF, 32'h12), "raw_issue");
        apply(mk(1, 0, 0, 32'h0,    7, 5, 1, 11, 1, 32'hDEAD_BEEF, 32'h12), "raw_stall");
`ifdef REGISTER_FILE_BYPASS_EN
        apply(mk(1, 1, 7, 32'h1234, 7, 5, 0, 0,  0, 32'h1234,      32'h12), "raw_wb");
`else
        apply(mk(1, 1, 7, 32'h1234, 7, 5, 0, 0,  1, 32'hDEAD_BEEF, 32'h12), "raw_wb");
        apply(mk(1, 0, 0, 32'h0,    7, 5, 0, 0,  0, 32'h1234,      32'h12), "raw_after");
`endif
        apply(mk(1, 0, 0, 32'h0,   11, 11, 0, 0, 0, 32'h0,         32'h0),  "dropped_issue");

        // Same-cycle issue and write-back on r8: the new issue keeps it pending.
        apply(mk(1, 0, 0, 32'h0,    0, 0, 1, 8,  0, 32'h0, 32'h0),  "setclr_issue");
        apply(mk(1, 1, 8, 32'h55,   0, 0, 1, 8,  0, 32'h0, 32'h0),  "setclr_same");
        apply(mk(1, 0, 0, 32'h0,    0, 8, 0, 0,  1, 32'h0, 32'h0),  "setclr_pend");
`ifdef REGISTER_FILE_BYPASS_EN
        apply(mk(1, 1, 8, 32'h66,   0, 8, 0, 0,  0, 32'h0, 32'h66), "setclr_wb");
`else
        apply(mk(1, 1, 8, 32'h66,   0, 8, 0, 0,  1, 32'h0, 32'h0),  "setclr_wb");
        apply(mk(1, 0, 0, 32'h0,    0, 8, 0, 0,  0, 32'h0, 32'h66), "setclr_after");
`endif

        // Reset clears a pending bit and the register contents.
        apply(mk(1, 0, 0, 32'h0,    0, 0, 1, 9,  0, 32'h0, 32'h0),  "rst_issue");
        apply(mk(1, 0, 0, 32'h0,    0, 9, 0, 0,  1, 32'h0, 32'h0),  "rst_pend");
        apply(mk(0, 0, 0, 32'h0,    0, 9, 0, 0,  0, 32'h0, 32'h0),  "rst_edge");
        apply(mk(1, 0, 0, 32'h0,    5, 9, 0, 0,  0, 32'h0, 32'h0),  "rst_after");
        apply(mk(1, 0, 0, 32'h0,    6, 8, 0, 0,  0, 32'h0, 32'h0),  "rst_regs");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width.
REQ-002 SHALL have parameter ADDR_W, default 5, register index width (2^ADDR_W registers).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port reg_write  input  1  write-back write enable.
REQ-006 SHALL have port wb_addr  input  ADDR_W  write-back destination index.
REQ-007 SHALL have port wb_data  input  DATA_W  write-back value (mem_to_reg-selected ALU or data-memory result).
REQ-008 SHALL have port rs_addr, rt_addr  input  ADDR_W each  decode-stage source indices.
REQ-009 SHALL have port rs_data, rt_data  output  DATA_W each  registered source operands.
REQ-010 SHALL have port issue_en  input  1  decode issuing an instruction that will write a register.
REQ-011 SHALL have port issue_dest  input  ADDR_W  destination of the issuing instruction.
REQ-012 SHALL have port stall  output  1  combinational; source operand pending write-back.

Function
REQ-013 SHALL hold 2^ADDR_W registers; register 0 reads as 0 and ignores writes.
REQ-014 SHALL write wb_data to register wb_addr at the rising edge when reg_write=1 and wb_addr!=0.
REQ-015 SHALL register rs_data/rt_data one cycle after rs_addr/rt_addr are presented (latency 1).
REQ-016 SHALL hold rs_data/rt_data unchanged in any cycle where stall=1.
REQ-017 SHALL keep a pending bit per register (scoreboard); bit 0 is permanently 0.
REQ-018 SHALL set pending[issue_dest] at the edge when issue_en=1, stall=0, issue_dest!=0.
REQ-019 SHALL clear pending[wb_addr] at the edge when reg_write=1.
REQ-020 SHALL, when set and clear hit the same index in one cycle, leave the bit set (new issue wins).
REQ-021 SHALL assert stall when (rs_addr!=0 and pending[rs_addr]) or (rt_addr!=0 and pending[rt_addr]), except as relaxed by REQ-027.
REQ-022 SHALL ignore issue_en while stall=1 (no scoreboard change).
REQ-023 SHALL treat rs_addr==rt_addr as a normal read on both ports.

Reset
REQ-024 SHALL, at a rising edge with rst_n=0, clear all registers, all pending bits, rs_data and rt_data to 0.
REQ-025 SHALL drive stall=0 while rst_n=0 and in the first cycle after reset.
REQ-026 SHALL discard a write-back or issue coincident with a reset edge.

Configuration
REQ-027 SHALL, with REGISTER_FILE_BYPASS_EN defined, forward wb_data to rs_data/rt_data when reg_write=1 and wb_addr equals the read index (nonzero), and not count that index as pending for stall in that cycle.
REQ-028 SHALL, without REGISTER_FILE_BYPASS_EN, return the pre-write register value on a same-cycle read and stall until pending clears (one extra cycle).

Structure
REQ-029 SHALL place DATA_W/ADDR_W defaults and the zero-register index constant in shared package cpu_pkg.
REQ-030 SHALL implement the pending-bit array as sub-module reg_scoreboard (set, clear, two lookups, stall).

Verification
REQ-031 SHALL cover: reset, then read rs=3,rt=4 -> rs_data=0, rt_data=0, stall=0.
REQ-032 SHALL cover: reg_write=1, wb_addr=5, wb_data=0x0000_0009; next cycle rs_addr=5 -> rs_data=9 one cycle later.
REQ-033 SHALL cover: reg_write=1, wb_addr=0, wb_data=0xFFFF_FFFF; then read rs_addr=0 -> rs_data=0.
REQ-034 SHALL cover: issue_en=1, issue_dest=7; next cycle rs_addr=7 -> stall=1; reg_write=1, wb_addr=7, wb_data=0x1234 -> with BYPASS_EN stall=0 that cycle and rs_data=0x1234 next edge; without, stall=1 that cycle, rs_data=0x1234 one cycle later.
REQ-035 SHALL cover: issue_dest=8 and reg_write wb_addr=8 in same cycle -> pending[8] remains 1, rt_addr=8 stalls.
REQ-036 SHALL cover: pending[9] set, rst_n=0 for one edge -> pending cleared, rt_addr=9 gives stall=0, rt_data=0.
